mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
//
// PURPOSE
// Round-robin arbiter that shares one 4:1 selection datapath between four
// requesters. Each requester offers a DATA_W word with a valid/ready handshake.
// The block picks one winner per cycle, registers the winner's word and index,
// and presents them on a single valid/ready output port.
// It sits in front of any consumer that previously took a statically selected mux output.
//
// PARAMETERS
// DATA_W   4   width of each requester word and of out_data
//
// PORTS
// clk         in   1        rising-edge clock
// rst_n       in   1        asynchronous reset, active-low
// in_valid    in   4        bit i = requester i offers in_data_i
// in_data_0   in   DATA_W   requester 0 word
// in_data_1   in   DATA_W   requester 1 word
// in_data_2   in   DATA_W   requester 2 word
// in_data_3   in   DATA_W   requester 3 word
// in_ready    out  4        one-hot or zero; bit i = word i accepted this cycle
// out_valid   out  1        out_data/out_src hold a word
// out_data    out  DATA_W   registered winning word
// out_src     out  2        index of requester that supplied out_data
// out_ready   in   1        consumer accepts out_data this cycle
//
// BEHAVIOUR
// - Clock, reset and reset values:
//   - Single clock domain.
//   - On rst_n low (async, immediate): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//   - in_ready is 0 during reset.
// - Output register FSM:
//   - States are EMPTY (out_valid=0) and FULL (out_valid=1).
//   - can_load = !out_valid | out_ready.
//   - load = can_load & |in_valid.
// - Grant selection:
//   - grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod 4.
//   - Purely combinational from in_valid and rr_ptr.
// - in_ready:
//   - in_ready[grant] = load; all other bits are 0.
//   - Combinational path out_ready -> in_ready is permitted.
// - On load, at the clock edge:
//   - out_data <= in_data_grant.
//   - out_src <= grant.
//   - out_valid <= 1.
//   - rr_ptr <= (grant+1) mod 4; after grant 3, rr_ptr wraps to 0.
// - Drain without refill: out_valid & out_ready & !load -> out_valid <= 0 (FULL->EMPTY).
// - Simultaneous drain and load: the output is replaced in the same cycle and stays FULL.
//   This gives one transfer per cycle sustained throughput.
// - Stall: while out_valid & !out_ready, the block holds out_data, out_src and rr_ptr
//   stable and keeps in_ready = 0.
// - Latency: a word accepted in cycle N appears on out_data in cycle N+1.
// - Idle: when no in_valid bit is set, rr_ptr is unchanged.
// - Fairness: a requester held valid waits at most 3 grants of other requesters.
// - Requester rule: in_data_i must be stable while in_valid[i] is high and
//   in_ready[i] is low; the block does not check this.
// - Reset mid-transfer: a held or pending word is discarded. The first grant
//   after reset goes to the lowest valid index (rr_ptr=0).
//
// TESTING
// 1. Reset: assert rst_n=0 asynchronously while out_valid=1
//    -> out_valid=0, out_data=0, out_src=0 before the next edge.
// 2. Single requester: in_valid=4'b0100, in_data_2=4'h5, out_ready=1
//    -> in_ready=4'b0100 the same cycle; next cycle out_valid=1, out_data=4'h5, out_src=2.
// 3. All four valid continuously with data 0,F,5,A and out_ready=1
//    -> out_src sequence 0,1,2,3,0 and out_data sequence 0,F,5,A,0, one word per cycle.
// 4. Backpressure: out_valid=1, out_ready=0 for 3 cycles, all requesters valid
//    -> in_ready=4'b0000, out_data/out_src stable; when out_ready=1 returns,
//    the next requester in round-robin order is granted.
// 5. Wrap and skip: grant 2, then only in_valid=4'b0011
//    -> requester 3 is skipped, requester 0 is granted, rr_ptr=1.
// 6. Drain to empty: single word, then in_valid=0 with out_ready=1
//    -> out_valid falls to 0 one cycle after the handshake.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four valid/ready requesters feeding one registered
// output slot; one winner per cycle, sustained one transfer per cycle.
module mux4_rr_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready
);

    // Handshake: a word moves across a port in any cycle where its valid and
    // ready are both high at the rising edge; valid never waits on ready.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_src_q, out_src_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic              can_load;
    logic              load;
    logic [1:0]        grant;
    logic              found;
    logic [1:0]        idx;
    logic [DATA_W-1:0] grant_data;

    // Scan starts at rr_ptr so the last winner is visited last.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_data = in_data_0;
        case (grant)
            2'd0: grant_data = in_data_0;
            2'd1: grant_data = in_data_1;
            2'd2: grant_data = in_data_2;
            2'd3: grant_data = in_data_3;
            default: grant_data = in_data_0;
        endcase
    end

    // rst_n gating keeps in_ready low while reset is held.
    assign can_load = (state_q == EMPTY) || out_ready;
    assign load     = can_load && found && rst_n;

    always_comb begin
        in_ready        = 4'b0000;
        in_ready[grant] = load;
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            state_d    = FULL;
            out_data_d = grant_data;
            out_src_d  = grant;
            rr_ptr_d   = grant + 2'd1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= 2'd0;
            rr_ptr_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: drivers push expected {src,data} words,
// a negedge monitor pops them on every output handshake.
module tb_mux4_rr_arbiter;
  localparam int DATA_W = 4;
  localparam int W = DATA_W + 2;

  logic              clk;
  logic              rst_n;
  logic [3:0]        in_valid;
  logic [DATA_W-1:0] in_data_0, in_data_1, in_data_2, in_data_3;
  logic [3:0]        in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              out_ready;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .in_data_2(in_data_2), .in_data_3(in_data_3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic ordy);
    step();
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic expect_word(input logic [1:0] src, input logic [DATA_W-1:0] data);
    exp_q.push_back({src, data});
  endtask

  task automatic mid_check_ready(input string name, input logic [3:0] exp);
    @(negedge clk);
    check(name, 8'(in_ready), 8'(exp));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got src=%0d data=%0h, queue empty", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_word", 8'({out_src, out_data}), 8'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b0;
    in_data_0 = 4'h0; in_data_1 = 4'hF; in_data_2 = 4'h5; in_data_3 = 4'hA;
    #2;
    check("rst_in_ready", 8'(in_ready), 8'h00);
    check("rst_out_valid", 8'(out_valid), 8'h0);
    @(posedge clk); #1;
    check("rst_out_data", 8'(out_data), 8'h0);
    check("rst_out_src", 8'(out_src), 8'h0);
    step();
    in_valid = 4'h0;
    rst_n = 1'b1;

    // all four valid, round-robin 0,1,2,3,0,1
    drive(4'hF, 1'b1); expect_word(2'd0, 4'h0); mid_check_ready("rr_ready0", 4'b0001);
    drive(4'hF, 1'b1); expect_word(2'd1, 4'hF); mid_check_ready("rr_ready1", 4'b0010);
    drive(4'hF, 1'b1); expect_word(2'd2, 4'h5); mid_check_ready("rr_ready2", 4'b0100);
    drive(4'hF, 1'b1); expect_word(2'd3, 4'hA); mid_check_ready("rr_ready3", 4'b1000);
    drive(4'hF, 1'b1); expect_word(2'd0, 4'h0); mid_check_ready("rr_ready4", 4'b0001);
    drive(4'hF, 1'b1); expect_word(2'd1, 4'hF); mid_check_ready("rr_ready5", 4'b0010);

    // backpressure: output holds {1,F}, nothing accepted
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 1'b0);
      @(negedge clk);
      check("stall_in_ready", 8'(in_ready), 8'h00);
      check("stall_out_data", 8'(out_data), 8'hF);
      check("stall_out_src", 8'(out_src), 8'h1);
      check("stall_out_valid", 8'(out_valid), 8'h1);
    end
    drive(4'hF, 1'b1); expect_word(2'd2, 4'h5); mid_check_ready("stall_release", 4'b0100);
    drive(4'h0, 1'b1);
    drive(4'h0, 1'b1);
    @(negedge clk);
    check("drain_empty_a", 8'(out_valid), 8'h0);

    // wrap and skip: grant 2, then only 0 and 1 valid
    in_data_0 = 4'h3; in_data_1 = 4'hC;
    drive(4'b0100, 1'b1); expect_word(2'd2, 4'h5); mid_check_ready("skip_g2", 4'b0100);
    drive(4'b0011, 1'b1); expect_word(2'd0, 4'h3); mid_check_ready("skip_g0", 4'b0001);
    drive(4'b0011, 1'b1); expect_word(2'd1, 4'hC); mid_check_ready("skip_g1", 4'b0010);
    drive(4'h0, 1'b1);
    drive(4'h0, 1'b1);
    @(negedge clk);
    check("drain_empty_b", 8'(out_valid), 8'h0);

    // single requester, then drain to empty
    drive(4'b0100, 1'b1); expect_word(2'd2, 4'h5); mid_check_ready("single_ready", 4'b0100);
    drive(4'h0, 1'b1);
    @(negedge clk);
    check("single_valid", 8'(out_valid), 8'h1);
    check("single_data", 8'(out_data), 8'h5);
    check("single_src", 8'(out_src), 8'h2);
    drive(4'h0, 1'b1);
    @(negedge clk);
    check("single_drained", 8'(out_valid), 8'h0);

    // idle keeps rr_ptr at 3, so requester 0 is granted after scanning 3
    drive(4'h0, 1'b1);
    in_data_0 = 4'h6;
    drive(4'b0001, 1'b1); expect_word(2'd0, 4'h6); mid_check_ready("idle_g0", 4'b0001);
    drive(4'h0, 1'b0);
    @(negedge clk);
    check("held_valid", 8'(out_valid), 8'h1);

    // async reset mid-cycle discards the held word
    step();
    #2;
    rst_n = 1'b0;
    in_valid = 4'hF;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 8'(out_valid), 8'h0);
    check("mid_rst_data", 8'(out_data), 8'h0);
    check("mid_rst_src", 8'(out_src), 8'h0);
    check("mid_rst_ready", 8'(in_ready), 8'h00);
    step();
    rst_n = 1'b1;
    in_valid = 4'h0;

    // rr_ptr back to 0: lowest valid index wins
    drive(4'b1011, 1'b1); expect_word(2'd0, 4'h6); mid_check_ready("post_rst_g0", 4'b0001);
    drive(4'h0, 1'b1);
    drive(4'h0, 1'b1);
    @(negedge clk);
    check("final_empty", 8'(out_valid), 8'h0);
    check("queue_empty", 8'(exp_q.size()), 8'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
